// File: rtl/ahb_avalon_bridge.sv
// ahb_avalon_bridge: AHB-Lite slave to Avalon-MM master, one transfer outstanding at a time
module ahb_avalon_bridge #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic            hclk,
    input  logic            hreset_n,
    input  logic            hsel,
    input  logic [AW-1:0]   haddr,
    input  logic [1:0]      htrans,
    input  logic [2:0]      hsize,
    input  logic            hwrite,
    input  logic [DW-1:0]   hwdata,
    input  logic            hready,
    output logic            hreadyout,
    output logic            hresp,
    output logic [DW-1:0]   hrdata,
    output logic [AW-1:0]   avm_address,
    output logic            avm_read,
    output logic            avm_write,
    output logic [DW-1:0]   avm_writedata,
    output logic [DW/8-1:0] avm_byteenable,
    input  logic [DW-1:0]   avm_readdata,
    input  logic            avm_waitrequest
);
    localparam int BW = DW / 8;
    localparam int LW = $clog2(BW);

    typedef enum logic [2:0] {IDLE, W_DATA, W_AVM, R_AVM, DONE, ERR1, ERR2} state_t;

    state_t        state;
    logic          accept;
    logic          legal;
    logic [BW-1:0] be;
    logic [AW-1:0] addr_al;

    // Address-phase decode: accept qualifier, size/alignment legality, lane mask, word address
    always_comb begin
        accept  = hsel && hready && (htrans == 2'b10 || htrans == 2'b11) &&
                  (state == IDLE || state == DONE || state == ERR2);
        legal   = (int'(hsize) <= LW) && ((haddr & ((AW'(1) << hsize) - AW'(1))) == '0);
        be      = '0;
        for (int i = 0; i < BW; i++)
            be[i] = (i >= int'(haddr[LW-1:0])) && (i < int'(haddr[LW-1:0]) + (1 << hsize));
        addr_al = {haddr[AW-1:LW], {LW{1'b0}}};
    end

    // Transfer FSM with all bus outputs registered
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state          <= IDLE;
            hreadyout      <= 1'b1;
            hresp          <= 1'b0;
            hrdata         <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR2: begin
                    hresp     <= accept && !legal;
                    hreadyout <= !accept;
                    if (!accept)
                        state <= IDLE;
                    else if (!legal)
                        state <= ERR1;
                    else begin
                        avm_address    <= addr_al;
                        avm_byteenable <= be;
                        avm_read       <= !hwrite;
                        state          <= hwrite ? W_DATA : R_AVM;
                    end
                end
                W_DATA: begin
                    avm_writedata <= hwdata;
                    avm_write     <= 1'b1;
                    state         <= W_AVM;
                end
                W_AVM: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        hreadyout <= 1'b1;
                        state     <= DONE;
                    end
                end
                R_AVM: begin
                    if (!avm_waitrequest) begin
                        hrdata    <= avm_readdata;
                        avm_read  <= 1'b0;
                        hreadyout <= 1'b1;
                        state     <= DONE;
                    end
                end
                ERR1: begin
                    hreadyout <= 1'b1;
                    state     <= ERR2;
                end
                default: begin
                    state     <= IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    avm_read  <= 1'b0;
                    avm_write <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_avalon_bridge.sv
// tb_ahb_avalon_bridge: directed transfers checked cycle-by-cycle against a transaction-level timeline model
module tb_ahb_avalon_bridge;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          hclk = 1'b0;
    logic          hreset_n = 1'b0;
    logic          hsel = 1'b0;
    logic [AW-1:0] haddr = '0;
    logic [1:0]    htrans = 2'b00;
    logic [2:0]    hsize = 3'd0;
    logic          hwrite = 1'b0;
    logic [DW-1:0] hwdata = '0;
    logic          hready = 1'b1;
    logic          hreadyout;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [3:0]    avm_byteenable;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_waitrequest = 1'b0;

    ahb_avalon_bridge #(.DW(DW), .AW(AW)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdat;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          wr_cyc = 0;
    int          rd_cyc = 0;
    logic        ready_resp = 1'b0;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] be_of(input logic [31:0] a, input logic [2:0] sz);
        int n = 1 << sz;
        int lo = int'(a % 4);
        return 4'(((1 << n) - 1) << lo);
    endfunction

    function automatic logic legal_of(input logic [31:0] a, input logic [2:0] sz);
        return (sz <= 3'd2) && ((a % (32'd1 << sz)) == 0);
    endfunction

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic push(input logic rdy, input logic resp, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        q.push_back('{rdy, resp, rd, wr, a, be, wd, last_rdata});
    endtask

    // Compare process: one expected record per cycle, sampled mid-cycle
    always @(negedge hclk) begin
        if (avm_write) wr_cyc++;
        if (avm_read) rd_cyc++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("hreadyout", hreadyout, e.rdy);
            chk("hresp", hresp, e.resp);
            chk("avm_read", avm_read, e.rd);
            chk("avm_write", avm_write, e.wr);
            chk("hrdata", hrdata, e.rdat);
            if (e.rd || e.wr) begin
                chk("avm_address", avm_address, e.addr);
                chk("avm_byteenable", avm_byteenable, e.be);
            end
            if (e.wr) chk("avm_writedata", avm_writedata, e.wd);
        end
    end

    // mode 0: unselected idle, 1: selected BUSY, 2: hsel low NONSEQ, 3: NONSEQ with hready low
    task automatic idle(input int mode);
        hsel   = (mode == 1 || mode == 3);
        htrans = (mode == 0) ? 2'b00 : (mode == 1) ? 2'b01 : 2'b10;
        hready = (mode != 3);
        haddr  = 32'h0000_0101;
        hsize  = 3'd3;
        hwrite = 1'b0;
        push(1'b1, ready_resp, 1'b0, 1'b0, '0, '0, '0);
        ready_resp = 1'b0;
        tick();
        hsel   = 1'b0;
        htrans = 2'b00;
        hready = 1'b1;
    endtask

    // One AHB transfer: address phase in the current cycle, returns positioned in its final ready cycle
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits);
        logic [3:0] be;
        be     = be_of(a, sz);
        hsel   = 1'b1;
        htrans = 2'b10;
        hready = 1'b1;
        haddr  = a;
        hsize  = sz;
        hwrite = wr;
        push(1'b1, ready_resp, 1'b0, 1'b0, '0, '0, '0);
        tick();
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = 32'hFFFF_FFF0;
        if (!legal_of(a, sz)) begin
            push(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
            tick();
            ready_resp = 1'b1;
            return;
        end
        if (wr) begin
            hwdata = wd;
            push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            tick();
            hwdata = ~wd;
            for (int i = 0; i <= waits; i++) begin
                avm_waitrequest = (i < waits);
                push(1'b0, 1'b0, 1'b0, 1'b1, a & ~32'd3, be, wd);
                tick();
            end
        end else begin
            for (int i = 0; i <= waits; i++) begin
                avm_waitrequest = (i < waits);
                avm_readdata    = (i < waits) ? (32'hBAD0_0000 | 32'(i)) : rd;
                push(1'b0, 1'b0, 1'b1, 1'b0, a & ~32'd3, be, '0);
                tick();
            end
            last_rdata = rd;
        end
        avm_waitrequest = 1'b0;
        ready_resp      = 1'b0;
    endtask

    initial begin
        int s_wr;
        int s_rd;
        tick();
        tick();
        chk("rst_hreadyout", hreadyout, 1'b1);
        chk("rst_hresp", hresp, 1'b0);
        chk("rst_hrdata", hrdata, '0);
        chk("rst_avm_read", avm_read, 1'b0);
        chk("rst_avm_write", avm_write, 1'b0);
        chk("rst_avm_address", avm_address, '0);
        chk("rst_avm_writedata", avm_writedata, '0);
        chk("rst_avm_byteenable", avm_byteenable, '0);
        hreset_n = 1'b1;

        chk("model_be_byte_102", be_of(32'h102, 3'd0), 4'b0100);
        chk("model_be_half_102", be_of(32'h102, 3'd1), 4'b1100);
        chk("model_be_word_100", be_of(32'h100, 3'd2), 4'b1111);
        chk("model_be_byte_103", be_of(32'h103, 3'd0), 4'b1000);

        idle(0);
        idle(1);
        idle(2);
        idle(3);

        s_wr = wr_cyc;
        xfer(1'b1, 32'h100, 3'd2, 32'hDEADBEEF, '0, 0);
        chk("word_write_strobe_cycles", 32'(wr_cyc - s_wr), 32'd1);

        s_rd = rd_cyc;
        xfer(1'b0, 32'h103, 3'd0, '0, 32'h11223344, 0);
        chk("byte_read_hrdata_done", hrdata, 32'h11223344);
        chk("byte_read_hreadyout_done", hreadyout, 1'b1);
        chk("byte_read_strobe_cycles", 32'(rd_cyc - s_rd), 32'd1);

        s_wr = wr_cyc;
        xfer(1'b1, 32'h102, 3'd1, 32'hA5A51234, '0, 4);
        chk("wait_write_strobe_cycles", 32'(wr_cyc - s_wr), 32'd5);

        s_wr = wr_cyc;
        s_rd = rd_cyc;
        xfer(1'b0, 32'h108, 3'd3, '0, '0, 0);
        xfer(1'b1, 32'h101, 3'd1, 32'h12345678, '0, 0);
        chk("error_strobe_cycles", 32'(wr_cyc - s_wr + rd_cyc - s_rd), 32'd0);

        xfer(1'b1, 32'h10, 3'd2, 32'h0BADF00D, '0, 0);
        xfer(1'b0, 32'h14, 3'd2, '0, 32'h13579BDF, 2);
        xfer(1'b0, 32'h102, 3'd0, '0, 32'hFFEEDDCC, 0);
        idle(0);
        idle(0);

        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr  = 32'h200;
        hsize  = 3'd2;
        tick();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = 32'hCAFEF00D;
        avm_waitrequest = 1'b1;
        tick();
        tick();
        chk("pre_reset_avm_write", avm_write, 1'b1);
        #2;
        hreset_n = 1'b0;
        #1;
        chk("mid_reset_avm_write", avm_write, 1'b0);
        chk("mid_reset_hreadyout", hreadyout, 1'b1);
        chk("mid_reset_avm_read", avm_read, 1'b0);
        chk("mid_reset_hrdata", hrdata, '0);
        tick();
        hreset_n        = 1'b1;
        avm_waitrequest = 1'b0;
        ready_resp      = 1'b0;
        last_rdata      = '0;
        xfer(1'b0, 32'h204, 3'd2, '0, 32'h55AA55AA, 1);
        chk("post_reset_read_hrdata", hrdata, 32'h55AA55AA);
        idle(0);
        idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
